// File: rtl/vend_sequencer.sv
// Vending sequencer: accumulates coin credit, accepts a product selection and
// drives the dispenser and change-hopper req/ack handshakes, refunding on cancel/timeout.
module vend_sequencer #(
  parameter int CW          = 6,
  parameter int PRICE_A     = 15,
  parameter int PRICE_B     = 20,
  parameter int MAX_CREDIT  = 35,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coin_valid,
  input  logic [1:0]    coin_val,
  input  logic          sel_valid,
  input  logic          sel_id,
  input  logic          cancel,
  input  logic          vend_ack,
  input  logic          chg_ack,
  output logic          coin_accept,
  output logic          coin_reject,
  output logic          sel_reject,
  output logic          vend_req,
  output logic          vend_id,
  output logic          chg_req,
  output logic [CW-1:0] credit,
  output logic          busy
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

  state_t        state_q;
  logic [CW-1:0] credit_q;
  logic [TW-1:0] timer_q;
  logic          coin_accept_q, coin_reject_q, sel_reject_q;
  logic          vend_req_q, vend_id_q, chg_req_q, busy_q;

  logic [CW-1:0] coin_amt;
  logic [CW:0]   coin_sum;
  logic [CW-1:0] price_sel;
  logic          in_credit, cancel_hit, sel_ok, coin_ok, timeout_hit, any_strobe;

  // Same-cycle priority is cancel > sel > coin; sel sees the pre-coin credit.
  always_comb begin
    coin_amt = '0;
    case (coin_val)
      2'b01:   coin_amt = CW'(5);
      2'b10:   coin_amt = CW'(10);
      default: coin_amt = '0;
    endcase
    coin_sum    = {1'b0, credit_q} + {1'b0, coin_amt};
    price_sel   = sel_id ? CW'(PRICE_B) : CW'(PRICE_A);
    in_credit   = (state_q == S_CREDIT);
    any_strobe  = coin_valid | sel_valid | cancel;
    cancel_hit  = in_credit & cancel;
    sel_ok      = in_credit & sel_valid & ~cancel & (credit_q >= price_sel);
    coin_ok     = coin_valid & ((state_q == S_IDLE) | in_credit) & (coin_amt != '0)
                & (coin_sum <= (CW+1)'(MAX_CREDIT)) & ~cancel_hit & ~sel_ok;
    timeout_hit = in_credit & ~any_strobe & (timer_q == TW'(TIMEOUT_CYC - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      timer_q       <= '0;
      coin_accept_q <= 1'b0;
      coin_reject_q <= 1'b0;
      sel_reject_q  <= 1'b0;
      vend_req_q    <= 1'b0;
      vend_id_q     <= 1'b0;
      chg_req_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      coin_accept_q <= coin_ok;
      coin_reject_q <= coin_valid & ~coin_ok;
      sel_reject_q  <= sel_valid & ~sel_ok;

      if (any_strobe)
        timer_q <= '0;
      else if (in_credit && timer_q != '1)
        timer_q <= timer_q + TW'(1);

      case (state_q)
        S_IDLE: begin
          if (coin_ok) begin
            credit_q <= coin_sum[CW-1:0];
            state_q  <= S_CREDIT;
          end
        end
        S_CREDIT: begin
          if (cancel_hit || timeout_hit) begin
            state_q   <= S_CHANGE;
            chg_req_q <= 1'b1;
            busy_q    <= 1'b1;
          end else if (sel_ok) begin
            credit_q   <= credit_q - price_sel;
            state_q    <= S_VEND;
            vend_req_q <= 1'b1;
            vend_id_q  <= sel_id;
            busy_q     <= 1'b1;
          end else if (coin_ok) begin
            credit_q <= coin_sum[CW-1:0];
          end
        end
        S_VEND: begin
          if (vend_ack && vend_req_q) begin
            vend_req_q <= 1'b0;
            if (credit_q != '0) begin
              state_q   <= S_CHANGE;
              chg_req_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        S_CHANGE: begin
          // Credit here is always a positive multiple of 5; the <=5 test keeps it from wrapping.
          if (chg_ack && chg_req_q) begin
            if (credit_q <= CW'(5)) begin
              credit_q  <= '0;
              state_q   <= S_IDLE;
              chg_req_q <= 1'b0;
              busy_q    <= 1'b0;
            end else begin
              credit_q <= credit_q - CW'(5);
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          vend_req_q <= 1'b0;
          chg_req_q  <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign coin_accept = coin_accept_q;
  assign coin_reject = coin_reject_q;
  assign sel_reject  = sel_reject_q;
  assign vend_req    = vend_req_q;
  assign vend_id     = vend_id_q;
  assign chg_req     = chg_req_q;
  assign credit      = credit_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer: coin, select, vend, change, timeout and reset scenarios.
module tb_vend_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_val = 2'b00;
  logic       sel_valid = 1'b0;
  logic       sel_id = 1'b0;
  logic       cancel = 1'b0;
  logic       vend_ack = 1'b0;
  logic       chg_ack = 1'b0;
  logic       coin_accept, coin_reject, sel_reject, vend_req, vend_id, chg_req, busy;
  logic [5:0] credit;

  int n_vec = 0;
  int n_err = 0;

  vend_sequencer dut (
    .clk(clk), .rst(rst),
    .coin_valid(coin_valid), .coin_val(coin_val),
    .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel),
    .vend_ack(vend_ack), .chg_ack(chg_ack),
    .coin_accept(coin_accept), .coin_reject(coin_reject), .sel_reject(sel_reject),
    .vend_req(vend_req), .vend_id(vend_id), .chg_req(chg_req),
    .credit(credit), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin_in(input logic [1:0] v);
    coin_valid = 1'b1; coin_val = v;
    tick();
    coin_valid = 1'b0; coin_val = 2'b00;
  endtask

  task automatic sel_in(input logic id);
    sel_valid = 1'b1; sel_id = id;
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic cancel_in();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  task automatic vend_ack_in();
    vend_ack = 1'b1;
    tick();
    vend_ack = 1'b0;
  endtask

  task automatic chg_ack_in();
    chg_ack = 1'b1;
    tick();
    chg_ack = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check_eq("rst_credit", credit, 0);
    check_eq("rst_outs", {coin_accept, coin_reject, sel_reject, vend_req, vend_id, chg_req, busy}, 0);
    rst = 1'b0;
    tick();

    // 5 + 10, sel A: exact payment, no change
    coin_in(2'b01);
    check_eq("t1_accept5", coin_accept, 1);
    check_eq("t1_credit5", credit, 5);
    coin_in(2'b10);
    check_eq("t1_credit15", credit, 15);
    sel_in(1'b0);
    check_eq("t1_vend_req", vend_req, 1);
    check_eq("t1_vend_id", vend_id, 0);
    check_eq("t1_credit0", credit, 0);
    check_eq("t1_busy", busy, 1);
    vend_ack_in();
    check_eq("t1_req_drop", vend_req, 0);
    check_eq("t1_no_chg", chg_req, 0);
    check_eq("t1_idle", busy, 0);

    // 10 + 10, sel A: one coin of change
    coin_in(2'b10);
    coin_in(2'b10);
    check_eq("t2_credit20", credit, 20);
    sel_in(1'b0);
    check_eq("t2_credit5", credit, 5);
    vend_ack_in();
    check_eq("t2_chg_req", chg_req, 1);
    check_eq("t2_busy", busy, 1);
    chg_ack_in();
    check_eq("t2_credit0", credit, 0);
    check_eq("t2_chg_drop", chg_req, 0);
    check_eq("t2_idle", busy, 0);

    // Four 10s: fourth exceeds MAX_CREDIT; cancel refunds 30 in six coins
    for (int i = 0; i < 3; i++) coin_in(2'b10);
    coin_in(2'b10);
    check_eq("t3_reject", coin_reject, 1);
    check_eq("t3_no_accept", coin_accept, 0);
    check_eq("t3_credit30", credit, 30);
    cancel_in();
    check_eq("t3_chg_req", chg_req, 1);
    for (int k = 1; k <= 6; k++) begin
      chg_ack_in();
      check_eq($sformatf("t3_drain%0d", k), credit, 30 - 5*k);
    end
    check_eq("t3_chg_drop", chg_req, 0);
    check_eq("t3_idle", busy, 0);
    chg_ack_in();
    check_eq("t3_spurious_chg", credit, 0);

    // 5 then sel B: rejected; inactivity timeout refunds
    coin_in(2'b01);
    sel_in(1'b1);
    check_eq("t4_sel_reject", sel_reject, 1);
    check_eq("t4_credit5", credit, 5);
    check_eq("t4_no_vend", vend_req, 0);
    for (int i = 0; i < 999; i++) tick();
    check_eq("t4_pre_timeout", chg_req, 0);
    tick();
    check_eq("t4_timeout", chg_req, 1);
    chg_ack_in();
    check_eq("t4_credit0", credit, 0);
    check_eq("t4_idle", busy, 0);

    // Boundary: credit exactly MAX_CREDIT accepted, then one more 5 rejected
    for (int i = 0; i < 3; i++) coin_in(2'b10);
    coin_in(2'b01);
    check_eq("b_accept35", coin_accept, 1);
    check_eq("b_credit35", credit, 35);
    coin_in(2'b01);
    check_eq("b_reject40", coin_reject, 1);
    check_eq("b_credit_hold", credit, 35);
    cancel_in();
    for (int k = 0; k < 7; k++) chg_ack_in();
    check_eq("b_drained", credit, 0);
    check_eq("b_idle", busy, 0);

    // Invalid coin codes and selection/ack while idle
    coin_in(2'b00);
    check_eq("b_inv00", coin_reject, 1);
    coin_in(2'b11);
    check_eq("b_inv11", {coin_accept, coin_reject}, 1);
    sel_in(1'b0);
    check_eq("b_sel_idle", sel_reject, 1);
    vend_ack_in();
    check_eq("b_spurious_vend", {vend_req, busy, 6'(credit)}, 0);

    // Credit 20: sel B with coin 5 in the same cycle
    coin_in(2'b10);
    coin_in(2'b10);
    sel_valid = 1'b1; sel_id = 1'b1; coin_valid = 1'b1; coin_val = 2'b01;
    tick();
    sel_valid = 1'b0; coin_valid = 1'b0; coin_val = 2'b00;
    check_eq("t5_vend_req", vend_req, 1);
    check_eq("t5_vend_id", vend_id, 1);
    check_eq("t5_coin_reject", coin_reject, 1);
    check_eq("t5_no_accept", coin_accept, 0);
    check_eq("t5_credit0", credit, 0);
    vend_ack_in();
    check_eq("t5_no_chg", chg_req, 0);
    check_eq("t5_idle", busy, 0);

    // Credit 20, sel A, asynchronous reset while vend_req is high
    coin_in(2'b10);
    coin_in(2'b10);
    sel_in(1'b0);
    check_eq("t6_vend_req", vend_req, 1);
    check_eq("t6_credit5", credit, 5);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_async_credit", credit, 0);
    check_eq("t6_async_outs", {coin_accept, coin_reject, sel_reject, vend_req, vend_id, chg_req, busy}, 0);
    #1 rst = 1'b0;
    tick();
    check_eq("t6_after_rst", {vend_req, chg_req, busy, 6'(credit)}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
